// File: rtl/data_mem_ctrl.sv
// Data-memory responder: decodes load/store requests from the core, steers byte
// lanes to a word-wide synchronous RAM, extends load results and stalls the core.
module data_mem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              mem_fault,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    RESP     = 3'd4,
    ERR      = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_re_q, mem_re_d;
  logic                mem_we_q, mem_we_d;
  logic [3:0]          mem_be_q, mem_be_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [2:0]          f3_q, f3_d;
  logic [1:0]          off_q, off_d;

  logic                req;
  logic                load_legal, store_legal, aligned, req_fault;
  logic [3:0]          st_be;
  logic [31:0]         st_wdata;
  logic                unused_addr_hi;

  // Upper address bits are deliberately dropped: accesses wrap modulo RAM size.
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // Request decode: legality, alignment and store lane steering.
  always_comb begin
    req         = MemRead | MemWrite;
    load_legal  = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b101);
    store_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    case (funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    req_fault = (MemRead & MemWrite) |
                (MemRead  & ~(load_legal  & aligned)) |
                (MemWrite & ~(store_legal & aligned));
    case (funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << addr[1:0];
        st_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        st_be    = addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{wdata[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = wdata;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    f3_d        = f3_q;
    off_d       = off_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (req_fault) begin
            state_d = ERR;
          end else if (MemWrite) begin
            state_d     = WR;
            mem_we_d    = 1'b1;
            mem_addr_d  = addr[ADDR_W+1:2];
            mem_be_d    = st_be;
            mem_wdata_d = st_wdata;
          end else begin
            state_d    = RD_ISSUE;
            mem_re_d   = 1'b1;
            mem_addr_d = addr[ADDR_W+1:2];
            mem_be_d   = 4'b0000;
            f3_d       = funct3;
            off_d      = addr[1:0];
          end
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        state_d = RESP;
        rdata_d = load_ext(f3_q, off_q, mem_rdata);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      f3_q        <= '0;
      off_q       <= '0;
    end else begin
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
    end
  end

  // Under reset the FSM is forced to IDLE, so stall tracks the request lines.
  always_comb begin
    if (rst) stall = req;
    else     stall = ((state_q == IDLE) & req) | (state_q == RD_ISSUE) | (state_q == RD_WAIT);
  end

  assign mem_fault = (state_q == ERR);
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule
